// File: rtl/enigma_pkg.sv
// +----------------------------------------------------------------------+
// | enigma_pkg: ASCII constants and formatter FSM state encoding. Rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

package enigma_pkg;

  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_CHAR = 3'd1,
    SEND_SP   = 3'd2,
    WAIT_SP   = 3'd3,
    SEND_CR   = 3'd4,
    WAIT_CR   = 3'd5,
    SEND_LF   = 3'd6,
    WAIT_LF   = 3'd7
  } fmt_state_t;

  // Out-of-range indices are deliberately not clamped.
  function automatic logic [7:0] idx_to_ascii(input logic [4:0] idx);
    return {3'b000, idx} + ASCII_A;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enigma_tx_formatter_if.sv
// +----------------------------------------------------------------------+
// | enigma_tx_formatter_if: cipher input, uart_tx link and status. Rev 1.0|
// +----------------------------------------------------------------------+
`default_nettype none

interface enigma_tx_formatter_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          clear_fmt;
  logic                          valid_in;
  logic [4:0]                    char_in;
  logic                          tx_busy;
  logic                          tx_done;
  logic                          tx_start;
  logic [7:0]                    tx_data;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          idle;

  modport master (
    input  clear_fmt, valid_in, char_in, tx_busy, tx_done,
    output tx_start, tx_data, fifo_count, overflow, idle
  );

  modport slave (
    output clear_fmt, valid_in, char_in, tx_busy, tx_done,
    input  tx_start, tx_data, fifo_count, overflow, idle
  );
endinterface

`default_nettype wire

// File: rtl/enigma_char_fifo.sv
// +----------------------------------------------------------------------+
// | enigma_char_fifo: first-word-fall-through character FIFO.   Rev 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module enigma_char_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH      = 5
) (
  input  wire logic                        clk,
  input  wire logic                        rst,
  input  wire logic                        push,
  input  wire logic                        pop,
  input  wire logic                        flush,
  input  wire logic [WIDTH-1:0]            din,
  output logic      [WIDTH-1:0]            dout,
  output logic                             full,
  output logic                             empty,
  output logic      [$clog2(FIFO_DEPTH):0] count
);
  localparam int             c_aw    = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty && !flush;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = push && !flush && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/enigma_tx_formatter.sv
// +----------------------------------------------------------------------+
// | enigma_tx_formatter: buffers cipher indices, emits grouped ASCII.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module enigma_tx_formatter
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int GROUP_LEN       = 5,
  parameter int GROUPS_PER_LINE = 6
) (
  input wire logic               clk,
  input wire logic               rst,
  enigma_tx_formatter_if.master  bus
);
  localparam int c_cw  = $clog2(FIFO_DEPTH) + 1;
  localparam int c_chw = $clog2(GROUP_LEN + 1);
  localparam int c_gw  = $clog2(GROUPS_PER_LINE + 1);
  localparam logic [c_chw-1:0] c_char_last = c_chw'(GROUP_LEN - 1);
  localparam logic [c_gw-1:0]  c_grp_last  = c_gw'(GROUPS_PER_LINE - 1);

  fmt_state_t        r_state;
  logic [c_chw-1:0]  r_char_cnt;
  logic [c_gw-1:0]   r_grp_cnt;
  logic              r_abort;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic              r_overflow;
  logic              r_idle;

  logic [4:0]        w_head;
  logic              w_full;
  logic              w_empty;
  logic [c_cw-1:0]   w_count;
  logic [c_cw-1:0]   w_count_next;
  logic              w_empty_next;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_abort_now;

  assign w_pop        = (r_state == IDLE) && !w_empty && !bus.tx_busy && !bus.clear_fmt;
  assign w_push       = bus.valid_in && !bus.clear_fmt && (!w_full || w_pop);
  assign w_drop       = bus.valid_in && !bus.clear_fmt && w_full && !w_pop;
  assign w_count_next = bus.clear_fmt ? '0 : (w_count + c_cw'(w_push) - c_cw'(w_pop));
  assign w_empty_next = (w_count_next == '0);
  // A clear seen while a byte is in flight cancels any separator that byte would trigger.
  assign w_abort_now  = r_abort || bus.clear_fmt;

  enigma_char_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (5)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (bus.clear_fmt),
    .din   (bus.char_in),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_char_cnt <= '0;
      r_grp_cnt  <= '0;
      r_abort    <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_overflow <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      r_tx_start <= 1'b0;
      r_idle     <= 1'b0;
      if (bus.clear_fmt) begin
        r_char_cnt <= '0;
        r_grp_cnt  <= '0;
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_abort <= 1'b0;
          if (w_pop) begin
            r_tx_data  <= idx_to_ascii(w_head);
            r_tx_start <= 1'b1;
            r_state    <= WAIT_CHAR;
          end else begin
            r_idle <= w_empty_next;
          end
        end
        WAIT_CHAR: begin
          if (bus.tx_done) begin
            r_abort <= 1'b0;
            if (w_abort_now) begin
              r_state <= IDLE;
              r_idle  <= w_empty_next;
            end else if (r_char_cnt == c_char_last) begin
              r_char_cnt <= '0;
              if (r_grp_cnt == c_grp_last) begin
                r_grp_cnt <= '0;
                r_state   <= SEND_CR;
              end else begin
                r_grp_cnt <= r_grp_cnt + c_gw'(1);
                r_state   <= SEND_SP;
              end
            end else begin
              r_char_cnt <= r_char_cnt + c_chw'(1);
              r_state    <= IDLE;
              r_idle     <= w_empty_next;
            end
          end else if (bus.clear_fmt) begin
            r_abort <= 1'b1;
          end
        end
        SEND_SP: begin
          if (bus.clear_fmt) begin
            r_state <= IDLE;
            r_idle  <= w_empty_next;
          end else if (!bus.tx_busy) begin
            r_tx_data  <= ASCII_SP;
            r_tx_start <= 1'b1;
            r_state    <= WAIT_SP;
          end
        end
        SEND_CR: begin
          if (bus.clear_fmt) begin
            r_state <= IDLE;
            r_idle  <= w_empty_next;
          end else if (!bus.tx_busy) begin
            r_tx_data  <= ASCII_CR;
            r_tx_start <= 1'b1;
            r_state    <= WAIT_CR;
          end
        end
        SEND_LF: begin
          if (bus.clear_fmt) begin
            r_state <= IDLE;
            r_idle  <= w_empty_next;
          end else if (!bus.tx_busy) begin
            r_tx_data  <= ASCII_LF;
            r_tx_start <= 1'b1;
            r_state    <= WAIT_LF;
          end
        end
        WAIT_CR: begin
          if (bus.tx_done) begin
            r_abort <= 1'b0;
            if (w_abort_now) begin
              r_state <= IDLE;
              r_idle  <= w_empty_next;
            end else begin
              r_state <= SEND_LF;
            end
          end else if (bus.clear_fmt) begin
            r_abort <= 1'b1;
          end
        end
        WAIT_SP, WAIT_LF: begin
          if (bus.tx_done) begin
            r_abort <= 1'b0;
            r_state <= IDLE;
            r_idle  <= w_empty_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.tx_start   = r_tx_start;
  assign bus.tx_data    = r_tx_data;
  assign bus.fifo_count = w_count;
  assign bus.overflow   = r_overflow;
  assign bus.idle       = r_idle;

endmodule

`default_nettype wire

// File: tb/tb_enigma_tx_formatter.sv
// +----------------------------------------------------------------------+
// | tb_enigma_tx_formatter: directed/random bench with byte-stream model.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_enigma_tx_formatter;
  localparam int FIFO_DEPTH      = 16;
  localparam int GROUP_LEN       = 5;
  localparam int GROUPS_PER_LINE = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         total = 0;
  int         bad = 0;
  int         tx_len = 10;
  int         model_letters = 0;
  logic       hold_busy = 1'b0;
  logic       u_busy;
  logic       u_done;
  int         u_cnt;
  logic [7:0] cur_data;
  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];
  logic [4:0] chars[20];

  enigma_tx_formatter_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  enigma_tx_formatter #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .GROUP_LEN       (GROUP_LEN),
    .GROUPS_PER_LINE (GROUPS_PER_LINE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.tx_busy = u_busy | hold_busy;
  assign bus.tx_done = u_done;

  // Transmitter model: busy for tx_len cycles after a start, done pulse at the end.
  always @(posedge clk) begin
    if (rst) begin
      u_busy <= 1'b0;
      u_done <= 1'b0;
      u_cnt  <= 0;
    end else begin
      u_done <= 1'b0;
      if (u_busy) begin
        if (u_cnt <= 1) begin
          u_busy <= 1'b0;
          u_done <= 1'b1;
        end
        u_cnt <= u_cnt - 1;
      end else if (bus.tx_start) begin
        u_busy <= 1'b1;
        u_cnt  <= tx_len;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.tx_start) begin
      chk("start_while_busy", {31'd0, bus.tx_busy}, 32'd0);
      sent_q.push_back(bus.tx_data);
      cur_data <= bus.tx_data;
    end
    if (!rst && u_done) chk("data_stable", {24'd0, bus.tx_data}, {24'd0, cur_data});
  end

  // Expected stream from the letter position since the last clear.
  function automatic void model_letter(input logic [4:0] c, input bit cut);
    exp_q.push_back(8'h41 + {3'b000, c});
    if (cut) begin
      model_letters = 0;
      return;
    end
    model_letters++;
    if (model_letters % GROUP_LEN == 0) begin
      if ((model_letters / GROUP_LEN) % GROUPS_PER_LINE == 0) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end else begin
        exp_q.push_back(8'h20);
      end
    end
  endfunction

  task automatic push_char(input logic [4:0] c);
    bus.valid_in = 1'b1;
    bus.char_in  = c;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear_fmt = 1'b1;
    @(posedge clk); #1;
    bus.clear_fmt = 1'b0;
    model_letters = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sent_q.size() < exp_q.size() || !bus.idle) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", {31'd0, n >= 20000}, 32'd0);
    repeat (200) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      chk({tag, "_byte"}, {24'd0, sent_q[i]}, {24'd0, exp_q[i]});
    sent_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.clear_fmt = 1'b0;
    bus.valid_in  = 1'b0;
    bus.char_in   = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'h00);
    chk("rst_fifo_count", {27'd0, bus.fifo_count}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("rst_idle", {31'd0, bus.idle}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single character
    tx_len = 10;
    push_char(5'd7);
    chk("single_count", {27'd0, bus.fifo_count}, 32'd1);
    chk("single_no_start_yet", {31'd0, bus.tx_start}, 32'd0);
    @(posedge clk); #1;
    chk("single_start", {31'd0, bus.tx_start}, 32'd1);
    chk("single_data", {24'd0, bus.tx_data}, 32'h48);
    chk("single_popped", {27'd0, bus.fifo_count}, 32'd0);
    model_letter(5'd7, 1'b0);
    wait_drain();
    check_stream("single");

    // Grouping: ABCDE FGHIJ K
    do_clear();
    tx_len = 100;
    for (int i = 0; i <= 10; i++) begin
      push_char(5'(i));
      model_letter(5'(i), 1'b0);
    end
    wait_drain();
    chk("group_sp1", {24'd0, sent_q[5]}, 32'h20);
    chk("group_sp2", {24'd0, sent_q[11]}, 32'h20);
    check_stream("group");

    // Line break after 30 letters, then a fresh group
    do_clear();
    tx_len = $urandom_range(3, 6);
    for (int i = 0; i < 35; i++) begin
      logic [4:0] c;
      c = 5'($urandom_range(0, 31));
      push_char(c);
      model_letter(c, 1'b0);
      repeat ($urandom_range(4, 10)) begin
        @(posedge clk); #1;
      end
    end
    wait_drain();
    chk("line_cr", {24'd0, sent_q[35]}, 32'h0D);
    chk("line_lf", {24'd0, sent_q[36]}, 32'h0A);
    chk("line_overflow", {31'd0, bus.overflow}, 32'd0);
    check_stream("line");

    // Overflow: 20 strobes while transmitter busy
    do_clear();
    tx_len = $urandom_range(3, 12);
    hold_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chars[i] = 5'($urandom_range(0, 25));
      push_char(chars[i]);
      if (i < FIFO_DEPTH) model_letter(chars[i], 1'b0);
    end
    chk("ovf_count", {27'd0, bus.fifo_count}, 32'd16);
    chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    hold_busy = 1'b0;
    wait_drain();
    chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    check_stream("ovf");
    do_clear();
    chk("ovf_cleared", {31'd0, bus.overflow}, 32'd0);

    // Full boundary: push and pop in the same cycle
    hold_busy = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      chars[i] = 5'($urandom_range(0, 25));
      push_char(chars[i]);
      model_letter(chars[i], 1'b0);
    end
    chk("full_count", {27'd0, bus.fifo_count}, 32'd16);
    chk("full_no_ovf", {31'd0, bus.overflow}, 32'd0);
    hold_busy = 1'b0;
    push_char(5'd25);
    model_letter(5'd25, 1'b0);
    chk("full_bnd_start", {31'd0, bus.tx_start}, 32'd1);
    chk("full_bnd_count", {27'd0, bus.fifo_count}, 32'd16);
    chk("full_bnd_ovf", {31'd0, bus.overflow}, 32'd0);
    wait_drain();
    check_stream("full");

    // clear_fmt while the 5th letter is on the wire
    do_clear();
    tx_len = 50;
    for (int i = 0; i < 5; i++) begin
      chars[i] = 5'($urandom_range(0, 25));
      push_char(chars[i]);
      model_letter(chars[i], i == 4);
    end
    begin
      int n = 0;
      while (sent_q.size() < 5 && n < 2000) begin
        @(posedge clk); #1;
        n++;
      end
      chk("clr_wait_timeout", {31'd0, n >= 2000}, 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    bus.clear_fmt = 1'b1;
    bus.valid_in  = 1'b1;
    bus.char_in   = 5'd3;
    @(posedge clk); #1;
    bus.clear_fmt = 1'b0;
    bus.valid_in  = 1'b0;
    model_letters = 0;
    chk("clr_count", {27'd0, bus.fifo_count}, 32'd0);
    chk("clr_no_ovf", {31'd0, bus.overflow}, 32'd0);
    wait_drain();
    chk("clr_idle", {31'd0, bus.idle}, 32'd1);
    chk("clr_count_after", {27'd0, bus.fifo_count}, 32'd0);
    check_stream("clr");
    tx_len = 8;
    for (int i = 0; i < 5; i++) begin
      chars[i] = 5'($urandom_range(0, 31));
      push_char(chars[i]);
      model_letter(chars[i], 1'b0);
    end
    wait_drain();
    check_stream("clr_fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
